// File: rtl/ln_interp.sv
// Natural log of an unsigned Q16.16 operand, returned as signed Q6.10.
// Leading-one range reduction, then linear interpolation between two entries of an external ln(1+m) ROM.
module ln_interp (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  output logic [9:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] ln_out,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    RD0,
    RD1,
    CALC,
    OUT
  } state_t;

  state_t state_q, state_n;

  logic        [31:0] x_q;
  logic signed [4:0]  e_q;
  logic        [8:0]  idx_q;
  logic        [9:0]  frac_q;
  logic signed [15:0] y0_q;
  logic signed [15:0] y1_q;

  logic        [4:0]  p;
  logic signed [4:0]  e_n;
  logic        [31:0] sh;
  logic        [30:0] f;

  logic signed [27:0] ex;
  logic signed [27:0] dv;
  logic signed [27:0] fv;
  logic signed [27:0] pv;
  logic signed [27:0] sum;

  always_comb begin
    p = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (x_q[i]) p = 5'(i);
    end
    e_n = $signed(p - 5'd16);
    sh  = x_q << (5'd31 - p);
    f   = sh[30:0];
  end

  // Interpolate: e*ln2 + y0 + ((y1-y0)*frac) >>> 10.
  always_comb begin
    ex  = 28'(e_q);
    dv  = 28'(y1_q) - 28'(y0_q);
    fv  = 28'({1'b0, frac_q});
    pv  = dv * fv;
    sum = ex * 28'sd710 + 28'(y0_q) + (pv >>> 10);
  end

  always_comb begin
    state_n  = state_q;
    rom_addr = 10'd0;
    unique case (state_q)
      IDLE: if (in_valid) state_n = NORM;
      NORM: state_n = (x_q == 32'd0) ? OUT : RD0;
      RD0: begin
        rom_addr = {1'b0, idx_q};
        state_n  = RD1;
      end
      RD1: begin
        rom_addr = {1'b0, idx_q} + 10'd1;
        state_n  = CALC;
      end
      CALC: state_n = OUT;
      OUT:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= 32'd0;
      e_q     <= 5'sd0;
      idx_q   <= 9'd0;
      frac_q  <= 10'd0;
      y0_q    <= 16'sd0;
      y1_q    <= 16'sd0;
      ln_out  <= 16'h0000;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      unique case (state_q)
        IDLE: if (in_valid) x_q <= x_in;
        NORM: begin
          if (x_q == 32'd0) begin
            ln_out <= 16'h8000;
            err    <= 1'b1;
          end else begin
            e_q    <= e_n;
            idx_q  <= f[30:22];
            frac_q <= f[21:12];
          end
        end
        RD0: y0_q <= $signed(rom_data);
        RD1: y1_q <= $signed(rom_data);
        CALC: begin
          ln_out <= sum[15:0];
          err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ln_interp.sv
// Directed testbench for ln_interp.
// ROM model is the real ln(1+k/512) table, or a 4k ramp when mock is set.
module tb_ln_interp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ln_out;
  logic        err;

  logic [15:0] tab [0:512];
  logic        mock;

  int checks = 0;
  int errors = 0;

  logic [15:0] r_ln;
  logic        r_err;
  int          r_lat;
  logic [9:0]  a_rd0;
  logic [9:0]  a_rd1;

  ln_interp dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ln_out    (ln_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    rom_data = 16'h0000;
    if (rom_addr <= 10'd512) begin
      if (mock) rom_data = 16'(rom_addr) << 2;
      else rom_data = tab[rom_addr];
    end
  end

  // Launch one operand, scramble x_in after accept, stop in OUT.
  task automatic run_op(input logic [31:0] x);
    in_valid = 1'b1;
    x_in     = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in     = ~x;
    r_lat    = 1;
    a_rd0    = 10'h3ff;
    a_rd1    = 10'h3ff;
    while (!out_valid && r_lat < 20) begin
      @(posedge clk);
      #1;
      r_lat++;
      if (r_lat == 2) a_rd0 = rom_addr;
      if (r_lat == 3) a_rd1 = rom_addr;
    end
    r_ln  = ln_out;
    r_err = err;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = 32'd0;
    mock      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (ln_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_ln_out got %h want 0000", ln_out);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b want 0", err);
    end
    checks++;
    if (rom_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_rom_addr got %0d want 0", rom_addr);
    end
  endtask

  task automatic test_unity();
    run_op(32'h0001_0000);
    checks++;
    if (r_lat !== 5) begin
      errors++;
      $display("FAIL one_latency got %0d want 5", r_lat);
    end
    checks++;
    if (r_ln !== 16'h0000 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL one_value got %h/%b want 0000/0", r_ln, r_err);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL one_in_ready_out got %b want 0", in_ready);
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL one_return_idle got %b/%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_pow2();
    run_op(32'h0002_0000);
    checks++;
    if (r_ln !== 16'h02C6) begin
      errors++;
      $display("FAIL two_value got %h want 02c6", r_ln);
    end
    consume();
    run_op(32'h0000_8000);
    checks++;
    if (r_ln !== 16'hFD3A) begin
      errors++;
      $display("FAIL half_value got %h want fd3a", r_ln);
    end
    consume();
    run_op(32'h0000_0001);
    checks++;
    if (r_ln !== 16'hD3A0) begin
      errors++;
      $display("FAIL min_value got %h want d3a0", r_ln);
    end
    consume();
  endtask

  task automatic test_zero();
    run_op(32'h0000_0000);
    checks++;
    if (r_lat !== 2) begin
      errors++;
      $display("FAIL zero_latency got %0d want 2", r_lat);
    end
    checks++;
    if (r_ln !== 16'h8000 || r_err !== 1'b1) begin
      errors++;
      $display("FAIL zero_value got %h/%b want 8000/1", r_ln, r_err);
    end
    consume();
    run_op(32'h0001_0000);
    checks++;
    if (r_ln !== 16'h0000 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_recover got %h/%b want 0000/0", r_ln, r_err);
    end
    consume();
  endtask

  task automatic test_mock();
    mock = 1'b1;
    run_op(32'h0001_0040);
    checks++;
    if (a_rd0 !== 10'd0 || a_rd1 !== 10'd1) begin
      errors++;
      $display("FAIL mock_addr got %0d,%0d want 0,1", a_rd0, a_rd1);
    end
    checks++;
    if (r_ln !== 16'd2) begin
      errors++;
      $display("FAIL mock_value got %h want 0002", r_ln);
    end
    consume();
    mock = 1'b0;
  endtask

  task automatic test_max();
    run_op(32'hFFFF_FFFF);
    checks++;
    if (a_rd0 !== 10'd511 || a_rd1 !== 10'd512) begin
      errors++;
      $display("FAIL max_addr got %0d,%0d want 511,512", a_rd0, a_rd1);
    end
    checks++;
    if (r_ln !== 16'h2C5F) begin
      errors++;
      $display("FAIL max_value got %h want 2c5f", r_ln);
    end
    consume();
  endtask

  task automatic test_backpressure();
    run_op(32'h0002_0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || ln_out !== 16'h02C6 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got v%b ln%h r%b want v1 ln02c6 r0",
                 i, out_valid, ln_out, in_ready);
      end
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int gap;
    run_op(32'h0000_8000);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x_in      = 32'h0002_0000;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle got %b want 1", in_ready);
    end
    run_op(32'h0002_0000);
    gap = r_lat + 1;
    checks++;
    if (gap !== 6 || r_ln !== 16'h02C6) begin
      errors++;
      $display("FAIL b2b_ii got %0d/%h want 6/02c6", gap, r_ln);
    end
    consume();
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1;
    x_in     = 32'h0002_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rom_addr !== 10'd1) begin
      errors++;
      $display("FAIL rst_in_rd1 got %0d want 1", rom_addr);
    end
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ln_out !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid got r%b v%b ln%h want r1 v0 ln0000",
               in_ready, out_valid, ln_out);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_no_result_%0d got v%b r%b want v0 r1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    for (int k = 0; k <= 512; k++) begin
      tab[k] = 16'($rtoi($ln(1.0 + real'(k) / 512.0) * 1024.0 + 0.5));
    end
    test_reset();
    test_unity();
    test_pow2();
    test_zero();
    test_mock();
    test_max();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
